// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding, opword layout.
// Latency: none; this file holds only types and constants.
// Backpressure: none; consumers apply stall and flush themselves.
package pipeline_pkg;

    // Fetch FSM: S_OP fetches an opword, S_IMM fetches the immediate word after it.
    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } fetch_state_t;

    // All-zero word is a NOP, so a bubble still decodes safely downstream.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Opword bit that announces a trailing immediate word.
    localparam int IMM_BIT_DEFAULT = 15;

    // Opword layout: opcode in [15:11], register fields and flags below.
    typedef struct packed {
        logic [4:0]  opcode;
        logic [10:0] fields;
    } opword_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register between fetch and decode.
// Latency: one cycle from load to output.
// Backpressure: holds its contents while load is low; flush inserts a bubble.
module ifid_reg
    import pipeline_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [N-1:0]  in_instr,
    input  logic [N-1:0]  in_imm,
    input  logic [AW-1:0] in_pc_next,
    output logic          out_valid,
    output logic [N-1:0]  out_instr,
    output logic [N-1:0]  out_imm,
    output logic [AW-1:0] out_pc_next
);

    // Reset and flush both leave an all-zero NOP bubble; otherwise load or hold.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid   <= 1'b0;
            out_instr   <= N'(NOP_INSTR);
            out_imm     <= '0;
            out_pc_next <= '0;
        end else if (load) begin
            out_valid   <= in_valid;
            out_instr   <= in_instr;
            out_imm     <= in_imm;
            out_pc_next <= in_pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one/two-word instruction assembly, drives IF/ID.
// Latency: one-word instr on IF/ID 1 cycle after pc=A; two-word after 2 cycles with one bubble.
// Backpressure: stall freezes pc, FSM and IF/ID; branch_taken redirects and flushes, beating stall.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int            N        = 16,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            IMM_BIT  = IMM_BIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [N-1:0]  imem_data,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic          ifid_valid,
    output logic [N-1:0]  ifid_instr,
    output logic [N-1:0]  ifid_imm,
    output logic [AW-1:0] ifid_pc_next
);

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    fetch_state_t  state;
    logic [N-1:0]  op_hold;

    logic          nxt_valid;
    logic [N-1:0]  nxt_instr;
    logic [N-1:0]  nxt_imm;
    logic [AW-1:0] nxt_pc_next;

    // Natural AW-bit wrap gives the modulo-2^AW PC arithmetic.
    assign pc_inc    = pc + {{(AW-1){1'b0}}, 1'b1};
    assign imem_addr = pc;

    // Next IF/ID contents: complete instruction when ready, bubble while an opword waits for its immediate.
    always_comb begin
        nxt_valid   = 1'b0;
        nxt_instr   = N'(NOP_INSTR);
        nxt_imm     = '0;
        nxt_pc_next = '0;
        case (state)
            S_OP: begin
                if (!imem_data[IMM_BIT]) begin
                    nxt_valid   = 1'b1;
                    nxt_instr   = imem_data;
                    nxt_pc_next = pc_inc;
                end
            end
            S_IMM: begin
                // The immediate is plain data; its top bit carries no meaning here.
                nxt_valid   = 1'b1;
                nxt_instr   = op_hold;
                nxt_imm     = imem_data;
                nxt_pc_next = pc_inc;
            end
            default: ;
        endcase
    end

    // PC and FSM: reset, then redirect, then stall-hold, then advance one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            state   <= S_OP;
            op_hold <= '0;
        end else if (branch_taken) begin
            pc      <= branch_target;
            state   <= S_OP;
            op_hold <= '0;
        end else if (!stall) begin
            pc <= pc_inc;
            case (state)
                S_OP: begin
                    if (imem_data[IMM_BIT]) begin
                        op_hold <= imem_data;
                        state   <= S_IMM;
                    end
                end
                S_IMM: state <= S_OP;
                default: state <= S_OP;
            endcase
        end
    end

    ifid_reg #(
        .N  (N),
        .AW (AW)
    ) u_ifid_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (!stall),
        .flush       (branch_taken),
        .in_valid    (nxt_valid),
        .in_instr    (nxt_instr),
        .in_imm      (nxt_imm),
        .in_pc_next  (nxt_pc_next),
        .out_valid   (ifid_valid),
        .out_instr   (ifid_instr),
        .out_imm     (ifid_imm),
        .out_pc_next (ifid_pc_next)
    );

endmodule
